// File: rtl/ddr_frame_pkg.sv
// ddr_frame_pkg: shared types and defaults for the DDR2 frame writer/reader pair
package ddr_frame_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_BANK_W = 2;
  localparam int DEF_BURST_LEN = 4;
  localparam int VGA_H = 640;
  localparam int VGA_V = 480;
  localparam int VGA_PIX_BITS = 8;
  localparam int DEF_FRAME_WORDS = VGA_H * VGA_V * VGA_PIX_BITS / DEF_DATA_W;
  typedef enum logic [1:0] {IDLE, WAIT, BURST} wr_state_t;
endpackage

// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer: drains the show-ahead pixel FIFO into DDR2 as fixed-length bursts per frame bank
module ddr_frame_writer
  import ddr_frame_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BANK_W = DEF_BANK_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic              wr_load,
  input  logic [15:0]       fifo_rdusedw,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              fifo_rdreq,
  input  logic              local_ready,
  output logic              local_write_req,
  output logic              local_burstbegin,
  output logic [ADDR_W-1:0] local_address,
  output logic [2:0]        local_size,
  output logic [DATA_W-1:0] local_wdata,
  output logic              frame_write_done
);
  localparam int OFF_W = ADDR_W - BANK_W;
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam logic [OFF_W-1:0] STEP = OFF_W'(BURST_LEN);
  localparam logic [OFF_W-1:0] FRAME_END = OFF_W'(FRAME_WORDS);
  wr_state_t state;
  logic [OFF_W-1:0] offset, next_off;
  logic [BEAT_W-1:0] beat_cnt;
  logic load_pend, last_beat, rewind;
  assign next_off = offset + STEP;
  assign fifo_rdreq = local_write_req & local_ready;
  assign last_beat = fifo_rdreq && beat_cnt == BEAT_W'(BURST_LEN - 1);
  assign rewind = load_pend | wr_load;
  assign local_burstbegin = local_write_req && beat_cnt == '0;
  assign local_size = 3'(BURST_LEN);
  assign local_wdata = fifo_q;
  // A load in WAIT takes that cycle to rewind, so a burst never starts from a stale offset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      offset <= '0;
      beat_cnt <= '0;
      load_pend <= 1'b0;
      local_write_req <= 1'b0;
      local_address <= '0;
      frame_write_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= WAIT;
          if (wr_load) begin
            offset <= '0;
            frame_write_done <= 1'b0;
          end
        end
        WAIT: begin
          if (wr_load) begin
            offset <= '0;
            frame_write_done <= 1'b0;
          end else if (!frame_write_done && fifo_rdusedw >= 16'(BURST_LEN)) begin
            state <= BURST;
            local_write_req <= 1'b1;
            local_address <= {wr_bank, offset};
          end
        end
        BURST: begin
          if (wr_load) load_pend <= 1'b1;
          if (fifo_rdreq) beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) begin
            state <= WAIT;
            local_write_req <= 1'b0;
            load_pend <= 1'b0;
            offset <= rewind ? '0 : next_off;
            frame_write_done <= !rewind && next_off == FRAME_END;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_frame_writer.sv
// tb_ddr_frame_writer: directed vectors plus randomized traffic against a burst-level reference model
module tb_ddr_frame_writer;
  logic clk = 1'b0, rst = 1'b1, wr_load = 1'b0, local_ready = 1'b0;
  logic [1:0] wr_bank = 2'd0;
  logic [15:0] fifo_rdusedw = '0;
  logic [63:0] fifo_q = '0;
  logic fifo_rdreq, local_write_req, local_burstbegin, frame_write_done;
  logic [23:0] local_address;
  logic [2:0] local_size;
  logic [63:0] local_wdata;

  ddr_frame_writer dut (
    .clk(clk), .rst(rst), .wr_bank(wr_bank), .wr_load(wr_load),
    .fifo_rdusedw(fifo_rdusedw), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .local_ready(local_ready), .local_write_req(local_write_req),
    .local_burstbegin(local_burstbegin), .local_address(local_address),
    .local_size(local_size), .local_wdata(local_wdata),
    .frame_write_done(frame_write_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, pop_cnt = 0;
  logic [63:0] fq[$];
  logic [63:0] push_val = 64'h1000;
  bit mon_en = 0, in_burst = 0, load_seen = 0;
  int beats = 0, bursts = 0;
  logic [21:0] exp_off = '0;
  logic [1:0] bank_prev = '0;
  logic [63:0] exp_word = '0;
  logic [23:0] burst_addr = '0;

  typedef struct {logic rdy; logic req; logic bb; int word;} vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fifo_sync();
    fifo_rdusedw = fq.size() > 65535 ? 16'hFFFF : 16'(fq.size());
    fifo_q = fq.size() != 0 ? fq[0] : '0;
  endtask

  task automatic push(input int n);
    repeat (n) begin
      fq.push_back(push_val);
      push_val++;
    end
    fifo_sync();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    fifo_sync();
    #1;
  endtask

  task automatic run_burst(input string nm, input logic [23:0] a);
    logic [63:0] base;
    int n;
    base = push_val;
    push(4);
    local_ready = 1'b1;
    n = 0;
    tick();
    while (!local_write_req && n < 20) begin
      tick();
      n++;
    end
    if (!local_write_req) chk({nm, "_start_timeout"}, 64'(local_write_req), 64'd1);
    else
      for (int i = 0; i < 4; i++) begin
        chk({nm, "_addr"}, 64'(local_address), 64'(a));
        chk({nm, "_wdata"}, local_wdata, base + 64'(i));
        tick();
      end
  endtask

  // Reference model: every burst starts at offset 0 if any load was seen since the previous burst began, else +4
  always @(posedge clk) begin
    if (mon_en) begin
      if (local_write_req) begin
        if (!in_burst) begin
          exp_off = load_seen ? 22'd0 : exp_off + 22'd4;
          load_seen = 0;
          burst_addr = {bank_prev, exp_off};
          in_burst = 1;
          beats = 0;
          bursts++;
        end
        chk("rnd_addr", 64'(local_address), 64'(burst_addr));
        chk("rnd_bb", 64'(local_burstbegin), 64'(beats == 0));
        if (fifo_rdreq) begin
          chk("rnd_wdata", local_wdata, exp_word);
          exp_word++;
          beats++;
          if (beats == 4) in_burst = 0;
        end
      end else if (in_burst) begin
        chk("rnd_truncated", 64'(beats), 64'd4);
        in_burst = 0;
      end
      if (wr_load) load_seen = 1;
    end
    bank_prev = wr_bank;
    if (fifo_rdreq) begin
      chk("fifo_underflow", 64'(fq.size() == 0), 64'd0);
      if (fq.size() != 0) void'(fq.pop_front());
      pop_cnt++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] base;
    int p0, acc, reqs;
    tbl = '{'{1'b0, 1'b1, 1'b1, 0}, '{1'b0, 1'b1, 1'b1, 0}, '{1'b0, 1'b1, 1'b1, 0},
            '{1'b1, 1'b1, 1'b1, 0}, '{1'b1, 1'b1, 1'b0, 1}, '{1'b0, 1'b1, 1'b0, 2},
            '{1'b1, 1'b1, 1'b0, 2}, '{1'b1, 1'b1, 1'b0, 3}, '{1'b1, 1'b0, 1'b0, -1}};
    repeat (3) tick();
    push(1);
    #1;
    chk("rst_req", 64'(local_write_req), 64'd0);
    chk("rst_bb", 64'(local_burstbegin), 64'd0);
    chk("rst_addr", 64'(local_address), 64'd0);
    chk("rst_done", 64'(frame_write_done), 64'd0);
    chk("rst_rdreq", 64'(fifo_rdreq), 64'd0);
    chk("rst_size", 64'(local_size), 64'd4);
    chk("rst_wdata", local_wdata, push_val - 64'd1);
    fq.delete();
    fifo_sync();

    rst = 1'b0;
    tick();
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    base = push_val;
    push(4);
    local_ready = 1'b1;
    p0 = pop_cnt;
    tick();
    chk("b_latency_req", 64'(local_write_req), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("b_req", 64'(local_write_req), 64'd1);
      chk("b_bb", 64'(local_burstbegin), 64'(i == 0));
      chk("b_addr", 64'(local_address), 64'h000000);
      chk("b_rdreq", 64'(fifo_rdreq), 64'd1);
      chk("b_wdata", local_wdata, base + 64'(i));
      tick();
    end
    chk("b_gap_req", 64'(local_write_req), 64'd0);
    chk("b_pops", 64'(pop_cnt - p0), 64'd4);

    wr_bank = 2'b11;
    base = push_val;
    push(4);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("c_addr", 64'(local_address), 64'hC00004);
      chk("c_wdata", local_wdata, base + 64'(i));
      if (i == 1) wr_bank = 2'b00;
      tick();
    end
    run_burst("c_next", 24'h000008);

    wr_bank = 2'b01;
    local_ready = 1'b0;
    base = push_val;
    push(4);
    p0 = pop_cnt;
    tick();
    for (int i = 0; i < 9; i++) begin
      local_ready = tbl[i].rdy;
      #1;
      chk("d_req", 64'(local_write_req), 64'(tbl[i].req));
      chk("d_bb", 64'(local_burstbegin), 64'(tbl[i].bb));
      chk("d_rdreq", 64'(fifo_rdreq), 64'(tbl[i].req & tbl[i].rdy));
      if (tbl[i].word >= 0) begin
        chk("d_addr", 64'(local_address), 64'h40000C);
        chk("d_wdata", local_wdata, base + 64'(tbl[i].word));
      end
      tick();
    end
    chk("d_pops", 64'(pop_cnt - p0), 64'd4);

    wr_bank = 2'b00;
    local_ready = 1'b1;
    push(4);
    tick();
    chk("e_addr", 64'(local_address), 64'h000010);
    tick();
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    tick();
    chk("e_beat3_req", 64'(local_write_req), 64'd1);
    tick();
    chk("e_end_req", 64'(local_write_req), 64'd0);
    chk("e_done", 64'(frame_write_done), 64'd0);
    run_burst("e_next", 24'h000000);

    push(4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("f_req", 64'(local_write_req), 64'd0);
    chk("f_bb", 64'(local_burstbegin), 64'd0);
    chk("f_addr", 64'(local_address), 64'd0);
    chk("f_done", 64'(frame_write_done), 64'd0);
    chk("f_rdreq", 64'(fifo_rdreq), 64'd0);
    rst = 1'b0;
    fq.delete();
    fifo_sync();
    run_burst("f_fresh", 24'h000000);

    in_burst = 0;
    load_seen = 0;
    exp_word = push_val;
    mon_en = 1;
    for (int i = 0; i < 2000; i++) begin
      local_ready = $urandom_range(0, 9) < 7;
      wr_load = (i == 0) || ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) < 3) push(1);
      if ($urandom_range(0, 9) == 0) wr_bank = 2'($urandom_range(0, 3));
      tick();
    end
    wr_load = 1'b0;
    local_ready = 1'b1;
    repeat (40) tick();
    chk("rnd_drained_req", 64'(local_write_req), 64'd0);
    chk("rnd_in_burst", 64'(in_burst), 64'd0);
    chk("rnd_bursts_seen", 64'(bursts > 20), 64'd1);
    mon_en = 0;
    fq.delete();
    fifo_sync();

    wr_bank = 2'b10;
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    acc = 0;
    for (int c = 0; c < 60000 && acc < 38400; c++) begin
      if (fq.size() < 8) push(8);
      #1;
      if (fifo_rdreq) begin
        if (acc == 38396) chk("g_last_addr", 64'(local_address), 64'h8095FC);
        acc++;
      end
      tick();
      if (acc == 38399) chk("g_done_early", 64'(frame_write_done), 64'd0);
    end
    chk("g_beats", 64'(acc), 64'd38400);
    chk("g_done", 64'(frame_write_done), 64'd1);
    push(20);
    reqs = 0;
    repeat (20) begin
      tick();
      if (local_write_req) reqs++;
    end
    chk("g_no_req", 64'(reqs), 64'd0);
    chk("g_done_hold", 64'(frame_write_done), 64'd1);
    wr_load = 1'b1;
    tick();
    wr_load = 1'b0;
    fq.delete();
    fifo_sync();
    #1;
    chk("g_done_cleared", 64'(frame_write_done), 64'd0);
    run_burst("g_after", 24'h800000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
